// File: rtl/pipeline_muldiv.sv
// HI/LO multiply/divide unit behind the ALU stage: pipelined multiplier, iterative
// restoring divider, and the HI/LO registers read by mfhi/mflo.
//
// state    | meaning
// IDLE     | no mult/div in flight; HI/LO stable
// MUL      | product travelling down the multiply pipeline
// DIV_ITER | restoring divide retiring DIV_BITS quotient bits per cycle
// DIV_FIX  | magnitudes done; apply result signs and write HI/LO
module pipeline_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] a0,
    input  logic [XLEN-1:0] a1,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            issue_err
);

    localparam logic [5:0] OP_MULT  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000101;
    localparam logic [5:0] OP_MTLO  = 6'b000110;
    localparam logic [5:0] OP_MULTU = 6'b000111;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b001001;

    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int PIPE      = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int MCW       = $clog2(PIPE) + 1;
    localparam int DCW       = $clog2(DIV_ITERS) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

    state_t              state, state_nxt;
    logic                is_mul, is_div, is_mthi, is_mtlo, op_sgn;
    logic                accept, abort, mul_wr, div_wr, err_nxt;
    logic [MCW-1:0]      mul_cnt;
    logic [2*XLEN-1:0]   mul_pipe [PIPE];
    logic [2*XLEN-1:0]   ext_a0, ext_a1, prod_now, mul_out;
    logic [XLEN-1:0]     a0_abs, a1_abs, div_rem, div_quo, div_dvs, q_fix, r_fix;
    logic                q_neg, r_neg, div_zero;
    logic [DCW-1:0]      div_cnt;
    logic [2*XLEN-1:0]   step_issue, step_iter;

    // DIV_BITS restoring steps; returns {remainder, quotient/dividend shift register}
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r_in,
                                                   input logic [XLEN-1:0] q_in,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0]   r;
        logic [XLEN-1:0] q;
        r = {1'b0, r_in};
        q = q_in;
        for (int i = 0; i < DIV_BITS; i++) begin
            r = {r[XLEN-1:0], q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        return {r[XLEN-1:0], q};
    endfunction

    always_comb begin
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        is_div     = (op == OP_DIV) || (op == OP_DIVU);
        is_mthi    = (op == OP_MTHI);
        is_mtlo    = (op == OP_MTLO);
        op_sgn     = (op == OP_MULT) || (op == OP_DIV);
        ext_a0     = {(op_sgn ? {XLEN{a0[XLEN-1]}} : {XLEN{1'b0}}), a0};
        ext_a1     = {(op_sgn ? {XLEN{a1[XLEN-1]}} : {XLEN{1'b0}}), a1};
        prod_now   = ext_a0 * ext_a1;
        a0_abs     = (op_sgn && a0[XLEN-1]) ? -a0 : a0;
        a1_abs     = (op_sgn && a1[XLEN-1]) ? -a1 : a1;
        mul_out    = (MUL_STAGES == 1) ? prod_now : mul_pipe[PIPE-1];
        step_issue = div_step('0, a0_abs, a1_abs);
        step_iter  = div_step(div_rem, div_quo, div_dvs);
        q_fix      = div_zero ? {XLEN{1'b1}} : (q_neg ? -div_quo : div_quo);
        r_fix      = r_neg ? -div_rem : div_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // flush frees the unit in the same cycle, so a simultaneous issue is accepted
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (is_mul) state_nxt = (MUL_STAGES == 1) ? IDLE : MUL;
            else        state_nxt = (DIV_ITERS == 1) ? DIV_FIX : DIV_ITER;
        end else if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                MUL:      if (mul_cnt == '0) state_nxt = IDLE;
                DIV_ITER: if (div_cnt == DCW'(1)) state_nxt = DIV_FIX;
                DIV_FIX:  state_nxt = IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        abort   = flush || (enable && (is_mthi || is_mtlo));
        accept  = enable && (is_mul || is_div) && (!busy || flush);
        err_nxt = enable && (is_mul || is_div) && busy && !flush;
        mul_wr  = ((state == MUL) && (mul_cnt == '0) && !abort) ||
                  ((MUL_STAGES == 1) && accept && is_mul);
        div_wr  = (state == DIV_FIX) && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            issue_err <= 1'b0;
            mul_cnt   <= '0;
            for (int i = 0; i < PIPE; i++) mul_pipe[i] <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_dvs   <= '0;
            div_cnt   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done      <= mul_wr || div_wr;
            issue_err <= err_nxt;
            if (mul_wr) {hi, lo} <= mul_out;
            if (div_wr) begin
                hi <= r_fix;
                lo <= q_fix;
            end
            // move-to writes land after any completing result
            if (enable && is_mthi) hi <= a0;
            if (enable && is_mtlo) lo <= a0;

            for (int i = 1; i < PIPE; i++) mul_pipe[i] <= mul_pipe[i-1];
            if (accept && is_mul) begin
                mul_pipe[0] <= prod_now;
                mul_cnt     <= MCW'(PIPE - 1);
            end else if ((state == MUL) && (mul_cnt != '0)) begin
                mul_cnt <= mul_cnt - MCW'(1);
            end

            if (accept && is_div) begin
                {div_rem, div_quo} <= step_issue;
                div_dvs  <= a1_abs;
                q_neg    <= op_sgn && (a0[XLEN-1] ^ a1[XLEN-1]);
                r_neg    <= op_sgn && a0[XLEN-1];
                div_zero <= (a1 == '0);
                div_cnt  <= DCW'(DIV_ITERS - 1);
            end else if (state == DIV_ITER) begin
                {div_rem, div_quo} <= step_iter;
                div_cnt <= div_cnt - DCW'(1);
            end
        end
    end

endmodule
